// File: rtl/mult_div_unit_if.sv
// Handshake/result bundle between the E-stage pipeline and the multiply/divide unit.
interface mult_div_unit_if;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        RdSel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    modport master (
        output Start, MDUOp, A, B, Req, RdSel,
        input  Busy, HI, LO, MDUOut
    );

    modport slave (
        input  Start, MDUOp, A, B, Req, RdSel,
        output Busy, HI, LO, MDUOut
    );
endinterface

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with architectural HI/LO and a fixed-latency Busy window.
// Define MDU_MADD_EN to implement madd/maddu/msub/msubu (ops 7-10); otherwise they are no-ops.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [3:0]  counter;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] pending;

    logic        op_valid;
    logic        is_div;
    logic        is_move;
    logic        accept;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_ovf;
    logic [31:0] div_b;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [63:0] result;

    always_comb begin
        op_valid = 1'b0;
        is_div   = 1'b0;
        is_move  = 1'b0;
        case (bus.MDUOp)
            4'd1, 4'd2: op_valid = 1'b1;
            4'd3, 4'd4: begin
                op_valid = 1'b1;
                is_div   = 1'b1;
            end
            4'd5, 4'd6: begin
                op_valid = 1'b1;
                is_move  = 1'b1;
            end
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: op_valid = 1'b1;
`endif
            default: ;
        endcase
    end

    assign accept = bus.Start & ~bus.Req & (state == IDLE) & op_valid;

    assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // Divisor is forced to 1 for zero and overflow cases so the divider never sees them.
    assign div_ovf = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
    assign div_b   = ((bus.B == 32'd0) || div_ovf) ? 32'd1 : bus.B;

    always_comb begin
        quot_s = 32'($signed(bus.A) / $signed(div_b));
        rem_s  = 32'($signed(bus.A) % $signed(div_b));
        quot_u = bus.A / div_b;
        rem_u  = bus.A % div_b;
        if (div_ovf) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
        end
    end

    // Divide by zero keeps the current HI/LO as the pending result.
    always_comb begin
        result = {hi_q, lo_q};
        case (bus.MDUOp)
            4'd1: result = prod_s;
            4'd2: result = prod_u;
            4'd3: if (bus.B != 32'd0) result = {rem_s, quot_s};
            4'd4: if (bus.B != 32'd0) result = {rem_u, quot_u};
`ifdef MDU_MADD_EN
            4'd7:  result = {hi_q, lo_q} + prod_s;
            4'd8:  result = {hi_q, lo_q} + prod_u;
            4'd9:  result = {hi_q, lo_q} - prod_s;
            4'd10: result = {hi_q, lo_q} - prod_u;
`endif
            default: ;
        endcase
    end

    // Result is captured at accept; HI/LO only change on the final Busy edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= 4'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pending <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_move) begin
                            if (bus.MDUOp == 4'd5) hi_q <= bus.A;
                            else                   lo_q <= bus.A;
                        end else begin
                            pending <= result;
                            counter <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                            busy_q  <= 1'b1;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    counter <= counter - 4'd1;
                    if (counter == 4'd1) begin
                        hi_q   <= pending[63:32];
                        lo_q   <= pending[31:0];
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Busy   = busy_q;
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;
    assign bus.MDUOut = bus.RdSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit: latency, HI/LO results, moves, Req and reset behaviour.
module tb_mult_div_unit;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;
    logic [63:0] sb_q[$];

    mult_div_unit_if bus ();

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge so the DUT samples them stable at the next rising edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
        bus.Start = 1'b1;
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        bus.Req   = req;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.MDUOp = 4'd0;
        bus.Req   = 1'b0;
    endtask

    task automatic doOp(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic req, input logic req_mid, input int cycles, input logic [63:0] expected);
        logic [63:0] got;
        int cnt;
        sb_q.push_back(expected);
        applyStimulus(op, a, b, req);
        if (cycles > 0) checkOutput({tag, "_stale_lo"}, bus.MDUOut, cur_lo);
        cnt = 0;
        while (bus.Busy === 1'b1 && cnt < 40) begin
            if (req_mid) bus.Req = 1'b1;
            cnt++;
            @(negedge clk);
        end
        bus.Req = 1'b0;
        checkOutput({tag, "_busy_cycles"}, 32'(cnt), 32'(cycles));
        got = sb_q.pop_front();
        checkOutput({tag, "_hi"}, bus.HI, got[63:32]);
        checkOutput({tag, "_lo"}, bus.LO, got[31:0]);
        cur_hi = got[63:32];
        cur_lo = got[31:0];
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        bus.Start = 1'b0;
        bus.MDUOp = 4'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.Req   = 1'b0;
        bus.RdSel = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        checkOutput("rst_busy", 32'(bus.Busy), 32'd0);
        checkOutput("rst_hi", bus.HI, 32'd0);
        checkOutput("rst_lo", bus.LO, 32'd0);
        checkOutput("rst_out_lo", bus.MDUOut, 32'd0);
        bus.RdSel = 1'b1;
        #1;
        checkOutput("rst_out_hi", bus.MDUOut, 32'd0);
        bus.RdSel = 1'b0;
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        doOp("mult",    4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 5,  64'hFFFF_FFFF_FFFF_FFFE);
        doOp("multu",   4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 5,  64'h0000_0001_FFFF_FFFE);
        doOp("div",     4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 10, 64'hFFFF_FFFF_FFFF_FFFD);
        doOp("divu_z",  4'd4, 32'd7,         32'd0, 1'b0, 1'b0, 10, 64'hFFFF_FFFF_FFFF_FFFD);
        doOp("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 10, 64'h0000_0000_8000_0000);
        doOp("divu",    4'd4, 32'd100,       32'd7, 1'b0, 1'b0, 10, 64'h0000_0002_0000_000E);
        doOp("mult_reqmid", 4'd1, 32'd3,     32'd4, 1'b0, 1'b1, 5,  64'h0000_0000_0000_000C);

        doOp("mthi", 4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 0, {32'h1234_5678, cur_lo});
        doOp("mtlo", 4'd6, 32'h0000_0009, 32'd0, 1'b0, 1'b0, 0, {32'h1234_5678, 32'h0000_0009});
        checkOutput("rdsel0_out", bus.MDUOut, 32'h0000_0009);
        bus.RdSel = 1'b1;
        #1;
        checkOutput("rdsel1_out", bus.MDUOut, 32'h1234_5678);
        bus.RdSel = 1'b0;

        doOp("mult_req", 4'd1, 32'd5, 32'd6, 1'b1, 1'b0, 0, {cur_hi, cur_lo});
        doOp("op11",     4'd11, 32'd5, 32'd6, 1'b0, 1'b0, 0, {cur_hi, cur_lo});
        doOp("op0",      4'd0, 32'd5, 32'd6, 1'b0, 1'b0, 0, {cur_hi, cur_lo});

`ifdef MDU_MADD_EN
        doOp("madd_sethi", 4'd5, 32'd0,         32'd0, 1'b0, 1'b0, 0, {32'd0, cur_lo});
        doOp("madd_setlo", 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 0, 64'h0000_0000_FFFF_FFFF);
        doOp("maddu", 4'd8, 32'd1, 32'd1, 1'b0, 1'b0, 5, 64'h0000_0001_0000_0000);
        doOp("msub",  4'd9, 32'd1, 32'd1, 1'b0, 1'b0, 5, 64'h0000_0000_FFFF_FFFF);
        doOp("madd",  4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 5, 64'h0000_0000_FFFF_FFFE);
`else
        doOp("madd_off",  4'd7, 32'd1, 32'd1, 1'b0, 1'b0, 0, {cur_hi, cur_lo});
        doOp("msubu_off", 4'd10, 32'd1, 32'd1, 1'b0, 1'b0, 0, {cur_hi, cur_lo});
`endif

        // Reset lands during the third Busy cycle of a divide and must discard it.
        applyStimulus(4'd4, 32'd100, 32'd3, 1'b0);
        checkOutput("rstmid_busy_started", 32'(bus.Busy), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rstmid_busy", 32'(bus.Busy), 32'd0);
        checkOutput("rstmid_hi", bus.HI, 32'd0);
        checkOutput("rstmid_lo", bus.LO, 32'd0);
        repeat (12) @(negedge clk);
        checkOutput("rstmid_hi_late", bus.HI, 32'd0);
        checkOutput("rstmid_lo_late", bus.LO, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
